// File: rtl/yin_pkg.sv
// Shared definitions for the YIN pitch-detection pipeline: default widths and
// lag range, plus the threshold-search FSM state encoding.
package yin_pkg;

  localparam int YIN_DATA_WIDTH = 64;
  localparam int YIN_MAX_TAU    = 40;
  localparam int YIN_MIN_TAU    = 2;
  localparam int YIN_TAU_BITS   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DESCEND = 2'd2,
    DONE    = 2'd3
  } search_state_t;

endpackage : yin_pkg

// File: rtl/threshold_search_module.sv
// Absolute-threshold lag search over the normalized-difference array.
// Lags MIN_TAU..MAX_TAU-1 are scanned one per cycle. The first lag whose
// value is below the threshold starts a descent to the local minimum, which
// becomes the result. If nothing crosses, the global minimum is reported
// instead, with ties resolved toward the lowest lag.
module threshold_search_module
  import yin_pkg::*;
#(
  parameter int INTERMEDIATE_DATA_WIDTH = YIN_DATA_WIDTH,
  parameter int MAX_TAU                 = YIN_MAX_TAU,
  parameter int MIN_TAU                 = YIN_MIN_TAU,
  parameter int TAU_BITS                = YIN_TAU_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] results [MAX_TAU],
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] threshold,
  output logic                               ready,
  output logic                               found,
  output logic [TAU_BITS-1:0]                tau_out,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0] min_value
);

  localparam logic [TAU_BITS-1:0] LAST_IDX = TAU_BITS'(MAX_TAU - 1);
  localparam logic [TAU_BITS-1:0] FIRST_IDX = TAU_BITS'(MIN_TAU);
  localparam logic [TAU_BITS-1:0] ONE_IDX = TAU_BITS'(1);
  localparam logic [INTERMEDIATE_DATA_WIDTH-1:0] ALL_ONES = '1;

  search_state_t                      state_reg, state_next;
  logic [TAU_BITS-1:0]                idx_reg, idx_next;
  logic [TAU_BITS-1:0]                best_idx_reg, best_idx_next;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] best_val_reg, best_val_next;
  logic                               start_d_reg;
  // Cleared while start is high across reset release, so a level that was
  // already asserted is not mistaken for a fresh rising edge.
  logic                               armed_reg;
  logic                               ready_next, found_next;
  logic [TAU_BITS-1:0]                tau_next;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] min_next;

  logic                               start_rise;
  logic [TAU_BITS-1:0]                peek_idx;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] cur_val, peek_val;
  logic                               scan_better;
  logic [TAU_BITS-1:0]                scan_best_idx;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] scan_best_val;

  // Next-state and next-output decode; the inputs are read live each cycle.
  always_comb begin
    start_rise    = start & ~start_d_reg & armed_reg;
    cur_val       = results[idx_reg];
    // Clamp the look-ahead index so the last lag never reads past the array.
    peek_idx      = (idx_reg == LAST_IDX) ? idx_reg : idx_reg + ONE_IDX;
    peek_val      = results[peek_idx];
    scan_better   = cur_val < best_val_reg;
    scan_best_idx = scan_better ? idx_reg : best_idx_reg;
    scan_best_val = scan_better ? cur_val : best_val_reg;

    state_next    = state_reg;
    idx_next      = idx_reg;
    best_idx_next = best_idx_reg;
    best_val_next = best_val_reg;
    ready_next    = ready;
    found_next    = found;
    tau_next      = tau_out;
    min_next      = min_value;

    unique case (state_reg)
      IDLE: begin
        if (start_rise) begin
          state_next    = SCAN;
          idx_next      = FIRST_IDX;
          best_idx_next = FIRST_IDX;
          best_val_next = ALL_ONES;
        end
      end
      SCAN: begin
        if (!start) begin
          state_next = IDLE;
        end else begin
          best_idx_next = scan_best_idx;
          best_val_next = scan_best_val;
          if (cur_val < threshold) begin
            state_next = DESCEND;
          end else if (idx_reg == LAST_IDX) begin
            state_next = DONE;
            ready_next = 1'b1;
            found_next = 1'b0;
            tau_next   = scan_best_idx;
            min_next   = scan_best_val;
          end else begin
            idx_next = idx_reg + ONE_IDX;
          end
        end
      end
      DESCEND: begin
        if (!start) begin
          state_next = IDLE;
        end else if ((idx_reg != LAST_IDX) && (peek_val < cur_val)) begin
          idx_next = peek_idx;
        end else begin
          state_next = DONE;
          ready_next = 1'b1;
          found_next = 1'b1;
          tau_next   = idx_reg;
          min_next   = cur_val;
        end
      end
      DONE: begin
        if (!start) begin
          state_next = IDLE;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      best_idx_reg <= '0;
      best_val_reg <= ALL_ONES;
      start_d_reg  <= 1'b0;
      armed_reg    <= ~start;
      ready        <= 1'b0;
      found        <= 1'b0;
      tau_out      <= '0;
      min_value    <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      best_idx_reg <= best_idx_next;
      best_val_reg <= best_val_next;
      start_d_reg  <= start;
      armed_reg    <= armed_reg | ~start;
      ready        <= ready_next;
      found        <= found_next;
      tau_out      <= tau_next;
      min_value    <= min_next;
    end
  end

endmodule : threshold_search_module

// File: tb/tb_threshold_search_module.sv
// Directed bench for threshold_search_module: expected results are queued as
// each search is launched and compared when ready rises.
module tb_threshold_search_module;

  localparam int W = 64;
  localparam int MAX_TAU = 40;
  localparam int TAU_BITS = 6;

  typedef struct {
    logic        found;
    int          tau;
    logic [W-1:0] min_v;
    int          lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [W-1:0]        results [MAX_TAU];
  logic [W-1:0]        threshold;
  logic                ready;
  logic                found;
  logic [TAU_BITS-1:0] tau_out;
  logic [W-1:0]        min_value;

  exp_t sb [$];
  int   total = 0;
  int   passed = 0;

  threshold_search_module dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .results   (results),
    .threshold (threshold),
    .ready     (ready),
    .found     (found),
    .tau_out   (tau_out),
    .min_value (min_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < MAX_TAU; i++) results[i] = base;
    results[0] = '0;  // lag 0 is never searched, so a zero there must be ignored
  endtask

  // Launch one search, wait for ready (bounded), compare against the queue.
  task automatic run_search(input string name, input logic exp_found, input int exp_tau,
                            input logic [W-1:0] exp_min, input int exp_lat);
    exp_t e;
    int   n;
    sb.push_back('{found: exp_found, tau: exp_tau, min_v: exp_min, lat: exp_lat});
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    e = sb.pop_front();
    $display("search %s: edges=%0d found=%0d tau=%0d min=%0d", name, n, found, tau_out, min_value);
    check({name, "_latency"}, W'(n), W'(e.lat));
    check({name, "_found"}, W'(found), W'(e.found));
    check({name, "_tau"}, W'(tau_out), W'(e.tau));
    check({name, "_min"}, min_value, e.min_v);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_ready_clear"}, W'(ready), W'(0));
    check({name, "_hold_tau"}, W'(tau_out), W'(e.tau));
  endtask

  initial begin
    int highs;
    reset = 1'b1;
    start = 1'b0;
    threshold = '0;
    fill(64'd500);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", W'(ready), W'(0));
    check("reset_found", W'(found), W'(0));
    check("reset_tau", W'(tau_out), W'(0));
    check("reset_min", min_value, W'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Crossing at lag 10, descent to local minimum at lag 12.
    fill(64'd500);
    for (int i = 13; i < MAX_TAU; i++) results[i] = 64'd300;
    results[10] = 64'd90; results[11] = 64'd80; results[12] = 64'd70;
    threshold = 64'd100;
    run_search("crossing", 1'b1, 12, 64'd70, 13);

    // No crossing: global-minimum fallback.
    fill(64'd500);
    results[25] = 64'd200;
    run_search("nocross", 1'b0, 25, 64'd200, 39);

    // Plateau: equality stops the descent at the first of the pair.
    fill(64'd500);
    results[5] = 64'd50; results[6] = 64'd50;
    run_search("plateau", 1'b1, 5, 64'd50, 6);

    // Same tie without a crossing keeps the lowest lag.
    threshold = 64'd10;
    run_search("tie_fallback", 1'b0, 5, 64'd50, 39);

    // Crossing on the very last lag.
    fill(64'd500);
    results[39] = 64'd10;
    threshold = 64'd100;
    run_search("last_lag", 1'b1, 39, 64'd10, 40);

    // Abort: start drops during the fifth SCAN cycle.
    fill(64'd500);
    for (int i = 13; i < MAX_TAU; i++) results[i] = 64'd300;
    results[10] = 64'd90; results[11] = 64'd80; results[12] = 64'd70;
    @(negedge clk);
    start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("abort: ready=%0d found=%0d tau=%0d min=%0d", ready, found, tau_out, min_value);
    check("abort_ready", W'(ready), W'(0));
    check("abort_found", W'(found), W'(1));
    check("abort_tau", W'(tau_out), W'(39));
    check("abort_min", min_value, W'(10));
    run_search("after_abort", 1'b1, 12, 64'd70, 13);

    // Reset while descending, with start held through reset release.
    @(negedge clk);
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("reset_mid: ready=%0d found=%0d tau=%0d min=%0d", ready, found, tau_out, min_value);
    check("rst_mid_ready", W'(ready), W'(0));
    check("rst_mid_found", W'(found), W'(0));
    check("rst_mid_tau", W'(tau_out), W'(0));
    check("rst_mid_min", min_value, W'(0));
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ready) highs++;
    end
    $display("start_held_after_reset: ready_cycles=%0d", highs);
    check("no_search_held_start", W'(highs), W'(0));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    run_search("after_reset", 1'b1, 12, 64'd70, 13);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_threshold_search_module

// File: doc/threshold_search_module.md
THRESHOLD_SEARCH_MODULE -- requirements
Module: threshold_search_module

Interface
REQ-001 SHALL have parameter INTERMEDIATE_DATA_WIDTH, default 64, width of each normalized-difference word and of threshold/min_value.
REQ-002 SHALL have parameter MAX_TAU, default 40, number of lag entries presented.
REQ-003 SHALL have parameter MIN_TAU, default 2, first lag searched; legal range 1 <= MIN_TAU <= MAX_TAU-1.
REQ-004 SHALL have parameter TAU_BITS, default 6, width of lag index; 2**TAU_BITS >= MAX_TAU.
REQ-005 SHALL use one clock and a synchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, level; driven by upstream normalized-difference ready.
REQ-008 SHALL have port results, input, INTERMEDIATE_DATA_WIDTH x MAX_TAU unpacked array, normalized difference per lag; index 0 is not searched.
REQ-009 SHALL have port threshold, input, INTERMEDIATE_DATA_WIDTH, absolute threshold, same fixed-point scale as results.
REQ-010 SHALL have port ready, output reg, 1, search result valid.
REQ-011 SHALL have port found, output reg, 1, 1 = threshold crossing found; 0 = global-minimum fallback.
REQ-012 SHALL have port tau_out, output reg, TAU_BITS, selected lag.
REQ-013 SHALL have port min_value, output reg, INTERMEDIATE_DATA_WIDTH, results[tau_out].

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DESCEND, DONE; reg start_d holds previous start.
REQ-015 IDLE: on an edge with start=1 and start_d=0, SHALL go to SCAN with idx=MIN_TAU, best_idx=MIN_TAU, best_val=all-ones.
REQ-016 SCAN: each cycle SHALL evaluate results[idx]; if results[idx] < best_val (strict), update best_idx/best_val, so ties keep the lowest lag.
REQ-017 SCAN: if results[idx] < threshold (strict), SHALL go to DESCEND with idx unchanged.
REQ-018 SCAN: else if idx == MAX_TAU-1, SHALL go to DONE with found=0, tau_out=best_idx, min_value=best_val (including the current-cycle update); else SHALL set idx=idx+1.
REQ-019 DESCEND: if idx+1 < MAX_TAU and results[idx+1] < results[idx], SHALL set idx=idx+1; otherwise (equality, or idx == MAX_TAU-1) SHALL go to DONE with found=1, tau_out=idx, min_value=results[idx].
REQ-020 DONE: ready SHALL be 1; outputs SHALL hold while start=1.
REQ-021 DONE: on start=0, SHALL clear ready and go to IDLE; found/tau_out/min_value SHALL hold until the next DONE entry.
REQ-022 SCAN/DESCEND: on start=0, SHALL abort to IDLE, ready stays 0, outputs unchanged.
REQ-023 Latency: with crossing lag t and local minimum m, ready SHALL be 1 after the (m - MIN_TAU + 3)th edge following the start-sampling edge; with no crossing, after the (MAX_TAU - MIN_TAU + 1)th edge.
REQ-024 Comparisons SHALL be unsigned, full INTERMEDIATE_DATA_WIDTH; no arithmetic beyond compare and idx increment.
REQ-025 results and threshold SHALL be sampled combinationally each cycle; upstream holds them stable while start=1; the block SHALL NOT latch the array.

Reset
REQ-026 reset SHALL force IDLE, ready=0, found=0, tau_out=0, min_value=0, idx=0, start_d=0, best_val=all-ones, in any state.
REQ-027 If start is already high when reset is released, no search SHALL begin until start falls and rises again.

Structure
REQ-028 Package yin_pkg SHALL hold MAX_TAU, MIN_TAU, TAU_BITS, INTERMEDIATE_DATA_WIDTH defaults and the FSM state enum; shared with the difference and normalization stages.
REQ-029 No sub-module: one registered FSM with a next-state combinational block; no arithmetic sub-module.

Verification
REQ-030 Crossing: defaults, threshold=100, results[2..9]=500, [10]=90, [11]=80, [12]=70, [13..39]=300, start rises -> ready after 13th edge, found=1, tau_out=12, min_value=70.
REQ-031 No crossing: all results[2..39]=500 except [25]=200, threshold=100 -> ready after 39th edge, found=0, tau_out=25, min_value=200.
REQ-032 Tie and plateau: results[5]=[6]=50, others 500, threshold=100 -> found=1, tau_out=5 (equality stops DESCEND); with threshold=10 -> found=0, tau_out=5.
REQ-033 Last-lag crossing: only results[39]=10, others 500, threshold=100 -> found=1, tau_out=39, ready after 40th edge.
REQ-034 Abort: start falls in cycle 5 of SCAN -> ready stays 0, state IDLE; new start rise -> full search, correct result.
REQ-035 Reset mid-DESCEND -> next cycle all outputs 0; start held high through reset release -> no ready until start falls and rises again.
